// File: rtl/dpram_param.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_param
//  Description : Parametrised dual-port RAM with post-reset zero fill, per-port
//                read enables/valids, configurable read latency and defined
//                same-address collision behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_param #(
    parameter int AWIDTH        = 11,
    parameter int NUM_WORDS     = 2048,
    parameter int DWIDTH        = 40,
    parameter int OUT_REGS      = 0,
    parameter bit WRITE_THROUGH = 1'b0,
    parameter bit CROSS_BYPASS  = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [AWIDTH-1:0] address_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              wren_a,
    input  logic              wren_b,
    input  logic              rden_a,
    input  logic              rden_b,
    input  logic [DWIDTH-1:0] data_a,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy
);

    // Stage 0 captures the request at its issue edge; stage L drives the port,
    // so a read issued at edge N appears at edge N+L.
    localparam int                c_LAT      = 1 + OUT_REGS;
    localparam int                c_STAGES   = c_LAT + 1;
    localparam logic [AWIDTH-1:0] c_LAST     = AWIDTH'(NUM_WORDS - 1);
    localparam logic [AWIDTH:0]   c_DEPTH    = NUM_WORDS[AWIDTH:0];
    localparam logic [0:0]        c_ST_INIT  = 1'b0;
    localparam logic [0:0]        c_ST_READY = 1'b1;

    logic [DWIDTH-1:0] r_mem [NUM_WORDS];
    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_cnt;

    logic              w_init_wr;
    logic              w_ready;
    logic              w_inr_a;
    logic              w_inr_b;
    logic              w_same;
    logic              w_wr_a;
    logic              w_wr_b;
    logic [1:0]        w_launch;
    logic [DWIDTH-1:0] w_rdat [2];
    logic [1:0]        w_vld_out;
    logic [DWIDTH-1:0] w_dat_out [2];

    assign w_init_wr = resetn && (r_state == c_ST_INIT);
    assign w_ready   = resetn && (r_state == c_ST_READY);
    assign w_inr_a   = ({1'b0, address_a} < c_DEPTH);
    assign w_inr_b   = ({1'b0, address_b} < c_DEPTH);
    assign w_same    = (address_a == address_b);

    // Port A wins a same-address write collision.
    assign w_wr_a = w_ready && wren_a && w_inr_a;
    assign w_wr_b = w_ready && wren_b && w_inr_b && !(wren_a && w_same);

    assign w_launch[0] = w_ready && (wren_a ? WRITE_THROUGH : rden_a);
    assign w_launch[1] = w_ready && (wren_b ? WRITE_THROUGH : rden_b);

    always_comb begin
        w_rdat[0] = '0;
        if (wren_a) begin
            w_rdat[0] = data_a;
        end else if (w_inr_a) begin
            w_rdat[0] = r_mem[address_a];
        end

        w_rdat[1] = '0;
        if (wren_b) begin
            w_rdat[1] = data_b;
        end else if (CROSS_BYPASS && wren_a && w_same && w_inr_b) begin
            w_rdat[1] = data_a;
        end else if (w_inr_b) begin
            w_rdat[1] = r_mem[address_b];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == c_ST_INIT) begin
            if (r_cnt == c_LAST) begin
                r_state <= c_ST_READY;
            end else begin
                r_cnt <= r_cnt + AWIDTH'(1);
            end
        end
    end

    // Reads above see the pre-edge contents, giving old-data collision reads.
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_cnt] <= '0;
        end
        if (w_wr_b) begin
            r_mem[address_b] <= data_b;
        end
        if (w_wr_a) begin
            r_mem[address_a] <= data_a;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [c_STAGES-1:0] r_vld;
        logic [DWIDTH-1:0]   r_dat [c_STAGES];

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_vld <= '0;
                for (int i = 0; i < c_STAGES; i++) begin
                    r_dat[i] <= '0;
                end
            end else begin
                r_vld[0] <= w_launch[p];
                if (w_launch[p]) begin
                    r_dat[0] <= w_rdat[p];
                end
                // Data only advances with a valid slot so the output holds otherwise.
                for (int i = 1; i < c_STAGES; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end
        end

        assign w_vld_out[p] = r_vld[c_STAGES-1];
        assign w_dat_out[p] = r_dat[c_STAGES-1];
    end

    assign out_a   = w_dat_out[0];
    assign out_b   = w_dat_out[1];
    assign valid_a = w_vld_out[0];
    assign valid_b = w_vld_out[1];
    assign busy    = (r_state == c_ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_dpram_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_param
//  Description : Self-checking bench for dpram_param; two instances (16x8 L=1
//                and 24x8 L=3 with write-through and cross bypass) share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_param;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] addr_a, addr_b;
    logic       wren_a, wren_b, rden_a, rden_b;
    logic [7:0] data_a, data_b;
    logic [7:0] out_a0, out_b0, out_a1, out_b1;
    logic       valid_a0, valid_b0, valid_a1, valid_b1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int n = 0;

    always #5 clk = ~clk;

    dpram_param #(.AWIDTH(4), .NUM_WORDS(16), .DWIDTH(8), .OUT_REGS(0),
                  .WRITE_THROUGH(1'b0), .CROSS_BYPASS(1'b0)) u0 (
        .clk(clk), .resetn(resetn),
        .address_a(addr_a[3:0]), .address_b(addr_b[3:0]),
        .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
        .data_a(data_a), .data_b(data_b),
        .out_a(out_a0), .out_b(out_b0), .valid_a(valid_a0), .valid_b(valid_b0),
        .busy(busy0));

    dpram_param #(.AWIDTH(5), .NUM_WORDS(24), .DWIDTH(8), .OUT_REGS(2),
                  .WRITE_THROUGH(1'b1), .CROSS_BYPASS(1'b1)) u1 (
        .clk(clk), .resetn(resetn),
        .address_a(addr_a), .address_b(addr_b),
        .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
        .data_a(data_a), .data_b(data_b),
        .out_a(out_a1), .out_b(out_b1), .valid_a(valid_a1), .valid_b(valid_b1),
        .busy(busy1));

    // Reference model: per-instance word array plus results scheduled by due edge.
    int         nw    [2] = '{16, 24};
    int         lat   [2] = '{1, 3};
    bit         wt    [2] = '{1'b0, 1'b1};
    bit         cb    [2] = '{1'b0, 1'b1};
    int         amask [2] = '{15, 31};
    logic [7:0] mmem  [2][32];
    int         initl [2] = '{0, 0};
    bit         sv    [2][2][8];
    logic [7:0] sd    [2][2][8];
    logic [7:0] lastout [2][2];
    bit         expv  [2][2];

    typedef struct {
        logic       wa, ra;
        logic [4:0] aa;
        logic [7:0] da;
        logic       wb, rb;
        logic [4:0] ab;
        logic [7:0] db;
        logic       eva;
        logic [7:0] eoa;
        logic       evb;
        logic [7:0] eob;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(bit wa, bit ra, int aa, int da, bit wb, bit rb, int ab, int db,
                                bit eva, int eoa, bit evb, int eob);
        vec_t v;
        v.wa = wa; v.ra = ra; v.aa = 5'(aa); v.da = 8'(da);
        v.wb = wb; v.rb = rb; v.ab = 5'(ab); v.db = 8'(db);
        v.eva = eva; v.eoa = 8'(eoa); v.evb = evb; v.eob = 8'(eob);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int a = int'(addr_a) & amask[k];
            int b = int'(addr_b) & amask[k];
            int due = (n + lat[k]) % 8;
            int slot = n % 8;
            if (!resetn) begin
                initl[k] = nw[k];
                for (int p = 0; p < 2; p++) begin
                    for (int s = 0; s < 8; s++) sv[k][p][s] = 1'b0;
                    lastout[k][p] = 8'h00;
                end
            end else if (initl[k] > 0) begin
                initl[k]--;
                if (initl[k] == 0) begin
                    for (int i = 0; i < 32; i++) mmem[k][i] = 8'h00;
                end
            end else begin
                if (wren_a ? wt[k] : rden_a) begin
                    sv[k][0][due] = 1'b1;
                    sd[k][0][due] = wren_a ? data_a : ((a >= nw[k]) ? 8'h00 : mmem[k][a]);
                end
                if (wren_b ? wt[k] : rden_b) begin
                    logic [7:0] v;
                    if (wren_b) v = data_b;
                    else if (b >= nw[k]) v = 8'h00;
                    else if (cb[k] && wren_a && a == b) v = data_a;
                    else v = mmem[k][b];
                    sv[k][1][due] = 1'b1;
                    sd[k][1][due] = v;
                end
                // B first, then A, so A wins a shared address.
                if (wren_b && b < nw[k]) mmem[k][b] = data_b;
                if (wren_a && a < nw[k]) mmem[k][a] = data_a;
            end
            for (int p = 0; p < 2; p++) begin
                expv[k][p] = sv[k][p][slot];
                if (sv[k][p][slot]) lastout[k][p] = sd[k][p][slot];
                sv[k][p][slot] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge();
        #1;
        check("u0_busy", busy0, initl[0] > 0);
        check("u0_valid_a", valid_a0, expv[0][0]);
        check("u0_valid_b", valid_b0, expv[0][1]);
        check("u0_out_a", out_a0, lastout[0][0]);
        check("u0_out_b", out_b0, lastout[0][1]);
        check("u1_busy", busy1, initl[1] > 0);
        check("u1_valid_a", valid_a1, expv[1][0]);
        check("u1_valid_b", valid_b1, expv[1][1]);
        check("u1_out_a", out_a1, lastout[1][0]);
        check("u1_out_b", out_b1, lastout[1][1]);
        @(negedge clk);
    endtask

    task automatic idle();
        wren_a = 1'b0; rden_a = 1'b0; addr_a = 5'd0; data_a = 8'h00;
        wren_b = 1'b0; rden_b = 1'b0; addr_b = 5'd0; data_b = 8'h00;
    endtask

    task automatic apply(input vec_t v);
        wren_a = v.wa; rden_a = v.ra; addr_a = v.aa; data_a = v.da;
        wren_b = v.wb; rden_b = v.rb; addr_b = v.ab; data_b = v.db;
    endtask

    task automatic rd_a(input int a);
        idle(); rden_a = 1'b1; addr_a = 5'(a);
    endtask

    task automatic wr_a(input int a, input int d);
        idle(); wren_a = 1'b1; addr_a = 5'(a); data_a = 8'(d);
    endtask

    task automatic count_busy(input string tag);
        int bc0 = 0;
        int bc1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy0) bc0++;
            if (busy1) bc1++;
            step();
        end
        check({tag, "_u0_busy_cycles"}, bc0, 16);
        check({tag, "_u1_busy_cycles"}, bc1, 24);
    endtask

    initial begin
        int k;
        int cnt;
        int first;
        int last;

        tbl[0] = mk(1,0,7,'h11, 1,0,7,'h22, 0,'h00,0,'h00);
        tbl[1] = mk(0,1,7,0,    0,1,7,0,    1,'h11,1,'h11);
        tbl[2] = mk(1,0,9,'h11, 0,0,0,0,    0,'h11,0,'h11);
        tbl[3] = mk(1,0,9,'h33, 0,1,9,0,    0,'h11,1,'h11);
        tbl[4] = mk(0,1,9,0,    0,0,0,0,    1,'h33,0,'h11);
        tbl[5] = mk(0,1,4,0,    1,0,4,'h5C, 1,'h00,0,'h11);
        tbl[6] = mk(0,1,4,0,    0,1,4,0,    1,'h5C,1,'h5C);
        tbl[7] = mk(1,0,5,'hA5, 0,0,0,0,    0,'h5C,0,'h5C);
        tbl[8] = mk(0,1,5,0,    0,1,15,0,   1,'hA5,1,'h00);
        tbl[9] = mk(0,0,0,0,    0,0,0,0,    0,'hA5,0,'h00);
        for (int k2 = 0; k2 < 2; k2++)
            for (int i = 0; i < 32; i++) mmem[k2][i] = 8'h00;

        idle();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        count_busy("init");

        // Every word reads back zero after the fill.
        cnt = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) rd_a(i); else idle();
            step();
            if (valid_a0 && out_a0 == 8'h00) cnt++;
        end
        check("u0_init_read_zero_valids", cnt, 16);

        // Directed vectors, checked one edge later against the L=1 instance.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) apply(tbl[i]); else idle();
            step();
            if (i > 0) begin
                check("tbl_valid_a", valid_a0, tbl[i-1].eva);
                check("tbl_out_a", out_a0, tbl[i-1].eoa);
                check("tbl_valid_b", valid_b0, tbl[i-1].evb);
                check("tbl_out_b", out_b0, tbl[i-1].eob);
            end
        end

        // Latency of the L=3 instance.
        wr_a(5, 'hA5); step();
        idle();
        for (int i = 0; i < 5; i++) step();
        rd_a(5); step();
        idle();
        k = 0;
        while (!valid_a1 && k < 10) begin
            step();
            k++;
        end
        check("u1_read_latency", k, 3);
        check("u1_read_data", out_a1, 8'hA5);

        // Back-to-back reads give one result per cycle.
        cnt = 0; first = -1; last = -1;
        for (int j = 0; j < 14; j++) begin
            if (j < 8) rd_a(j); else idle();
            step();
            if (valid_a1) begin
                if (first < 0) first = j;
                last = j;
                cnt++;
            end
        end
        check("u1_b2b_count", cnt, 8);
        check("u1_b2b_first", first, 3);
        check("u1_b2b_span", last - first, 7);

        // Write-through on u1, hold on u0.
        wr_a(12, 'h3C); step();
        check("u0_wt0_no_valid", valid_a0, 1'b0);
        idle(); step(); step(); step();
        check("u1_wt1_valid", valid_a1, 1'b1);
        check("u1_wt1_data", out_a1, 8'h3C);

        // Out-of-range on the 24-word instance.
        wr_a(30, 'hFF); step();
        idle();
        for (int i = 0; i < 4; i++) step();
        rd_a(30); step();
        idle(); step(); step(); step();
        check("u1_oor_valid", valid_a1, 1'b1);
        check("u1_oor_data", out_a1, 8'h00);

        // Reset with two reads in flight.
        rd_a(1); step();
        rd_a(2); step();
        idle();
        resetn = 1'b0; step();
        check("rst_u1_valid_a", valid_a1, 1'b0);
        check("rst_u1_out_a", out_a1, 8'h00);
        check("rst_u0_out_a", out_a0, 8'h00);
        step();
        check("rst_u1_valid_a_2", valid_a1, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) step();
        resetn = 1'b0; step();
        resetn = 1'b1;
        count_busy("reinit");

        // Randomised traffic with collisions and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int ra = $urandom_range(0, 3);
            int rb = $urandom_range(0, 3);
            resetn = ($urandom_range(0, 149) != 0);
            addr_a = 5'($urandom_range(0, 31));
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 5'($urandom_range(0, 31));
            data_a = 8'($urandom);
            data_b = 8'($urandom);
            wren_a = (ra == 3);
            rden_a = (ra == 1 || ra == 2 || ($urandom_range(0, 7) == 0));
            wren_b = (rb == 3);
            rden_b = (rb == 1 || rb == 2 || ($urandom_range(0, 7) == 0));
            step();
        end
        resetn = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
